mult_div_unit: RTL

- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Decode issues MULT/MULTU/DIV/DIVU operands here instead of to the ALU.
- The unit owns the architectural HI/LO registers, which feed the MFHI/MFLO path into the writeback mux.
- It also accepts MTHI/MTLO writes and raises busy so the hazard unit can stall MFHI/MFLO and new issues.

---
 rtl/mult_div_unit_pkg.sv | 6 +
 rtl/mult_div_unit_if.sv | 18 +
 rtl/md_step.sv | 18 +
 rtl/mult_div_unit.sv | 76 +++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op and state encodings plus iteration count shared by the multiply/divide unit and its bench
package mult_div_unit_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'd0, MD_MULTU = 2'd1, MD_DIV = 2'd2, MD_DIVU = 2'd3} md_op_t;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_RUN = 2'd1, MD_FIX = 2'd2} md_state_t;
  localparam int MD_ITER = 32;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/flush/mthi/mtlo requests from decode (master) to the unit (slave); busy/done/hi/lo back
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;
  logic md_start;
  md_op_t md_op;
  logic [31:0] md_op_x;
  logic [31:0] md_op_y;
  logic md_flush;
  logic mthi_we;
  logic mtlo_we;
  logic [31:0] md_wdata;
  logic md_busy;
  logic md_done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output md_start, md_op, md_op_x, md_op_y, md_flush, mthi_we, mtlo_we, md_wdata, input md_busy, md_done, hi, lo);
  modport slave (input md_start, md_op, md_op_x, md_op_y, md_flush, mthi_we, mtlo_we, md_wdata, output md_busy, md_done, hi, lo);
endinterface

// File: rtl/md_step.sv
// md_step: one radix-2 iteration; is_div selects restoring shift-subtract, else shift-add; acc_hi/acc_lo/b in, nxt_hi/nxt_lo out
module md_step (
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] b,
  output logic [31:0] nxt_hi,
  output logic [31:0] nxt_lo
);
  logic [32:0] sum, shl, diff;
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : 33'd0);
    shl = {acc_hi, acc_lo[31]};
    diff = shl - {1'b0, b};
    nxt_hi = is_div ? (diff[32] ? shl[31:0] : diff[31:0]) : sum[32:1];
    nxt_lo = is_div ? {acc_lo[30:0], ~diff[32]} : {sum[0], acc_lo[31:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: 34-cycle iterative MULT/MULTU/DIV/DIVU owning HI/LO; ports clk, rst, md (slave: issue, flush, mthi/mtlo in; busy, done, hi, lo out)
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input logic clk,
  input logic rst,
  mult_div_unit_if.slave md
);
  md_state_t state, state_nxt;
  logic [4:0] cnt;
  logic [31:0] acc_hi, acc_lo, b_q, x_q, step_hi, step_lo, res_hi, res_lo, ax, ay;
  logic [63:0] prod;
  logic div_q, qs_q, rs_q, dz_q, sgn, is_div, go, wr_ok;
  md_step u_step (.is_div(div_q), .acc_hi(acc_hi), .acc_lo(acc_lo), .b(b_q), .nxt_hi(step_hi), .nxt_lo(step_lo));
  assign md.md_busy = state != MD_IDLE;
  always_ff @(posedge clk) state <= rst ? MD_IDLE : state_nxt;
  always_comb begin
    state_nxt = md.md_flush ? MD_IDLE
              : state == MD_IDLE ? (md.md_start ? MD_RUN : MD_IDLE)
              : state == MD_RUN ? (cnt == 5'd0 ? MD_FIX : MD_RUN)
              : MD_IDLE;
  end
  always_comb begin
    sgn = md.md_op == MD_MULT || md.md_op == MD_DIV;
    is_div = md.md_op == MD_DIV || md.md_op == MD_DIVU;
    ax = (sgn && md.md_op_x[31]) ? -md.md_op_x : md.md_op_x;
    ay = (sgn && md.md_op_y[31]) ? -md.md_op_y : md.md_op_y;
    go = state == MD_IDLE && md.md_start && !md.md_flush;
    wr_ok = state == MD_IDLE && !md.md_flush;
    prod = qs_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    res_lo = !div_q ? prod[31:0] : dz_q ? 32'hFFFFFFFF : qs_q ? -acc_lo : acc_lo;
    res_hi = !div_q ? prod[63:32] : dz_q ? x_q : rs_q ? -acc_hi : acc_hi;
  end
  // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
  // divide keeps the dividend in acc_lo and shifts quotient bits in from the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      md.hi <= '0;
      md.lo <= '0;
      md.md_done <= 1'b0;
      cnt <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      b_q <= '0;
      x_q <= '0;
      div_q <= 1'b0;
      qs_q <= 1'b0;
      rs_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      md.md_done <= state == MD_FIX && !md.md_flush;
      if (wr_ok && md.mthi_we) md.hi <= md.md_wdata;
      if (wr_ok && md.mtlo_we) md.lo <= md.md_wdata;
      if (go) begin
        div_q <= is_div;
        x_q <= md.md_op_x;
        b_q <= is_div ? ay : ax;
        acc_lo <= is_div ? ax : ay;
        acc_hi <= '0;
        qs_q <= sgn && (md.md_op_x[31] ^ md.md_op_y[31]);
        rs_q <= sgn && md.md_op_x[31];
        dz_q <= is_div && md.md_op_y == '0;
        cnt <= 5'(MD_ITER - 1);
      end
      if (state == MD_RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt <= cnt - 5'd1;
      end
      if (state == MD_FIX && !md.md_flush) begin
        md.hi <= res_hi;
        md.lo <= res_lo;
      end
    end
  end
endmodule
